// File: rtl/mlp_pkg.sv
// Shared types and width helpers for the MLP inference sequencer.
package mlp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT_W,
      LOAD_X,
      ACC,
      DRAIN,
      WB,
      STORE_X
   } state_t;

   // Counter width that stays legal for a limit of 1 or 2.
   function automatic int cnt_w(input int limit);
      return (limit <= 2) ? 1 : $clog2(limit);
   endfunction

   function automatic int layer_w(input int num_layers);
      return $clog2(num_layers + 1);
   endfunction

   function automatic int dim_w(input int dim);
      return $clog2(dim);
   endfunction

   function automatic int waddr_w(input int num_layers, input int dim);
      return $clog2(num_layers * dim * dim);
   endfunction

endpackage

// File: rtl/mlp_seq_counter.sv
// Wrap counter: counts 0..Limit-1, flags the increment that wraps back to 0.
module counter import mlp_pkg::*; #(
   parameter int Limit = 4,
   parameter int Width = cnt_w(Limit)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [Width-1:0] value_o,
   output logic             will_overflow_o
);

   assign will_overflow_o = inc_i && (value_o == Width'(Limit - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_o <= '0;
      end else if (clr_i || will_overflow_o) begin
         value_o <= '0;
      end else if (inc_i) begin
         value_o <= value_o + Width'(1);
      end
   end

endmodule

// File: rtl/mlp_seq.sv
// Sequencer for the MLP datapath: weight load, input load, layer compute, result stream.
module mlp_seq import mlp_pkg::*; #(
   parameter int NumLayers = 8,
   parameter int Dim       = 16,
   parameter int LayerW    = layer_w(NumLayers),
   parameter int DimW      = dim_w(Dim),
   parameter int WAddrW    = waddr_w(NumLayers, Dim)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              abort_i,
   input  logic              init_valid_i,
   output logic              init_ready_o,
   input  logic              start_valid_i,
   output logic              start_ready_o,
   input  logic [LayerW-1:0] start_layers_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              result_valid_o,
   input  logic              result_ready_i,
   output logic              result_last_o,
   output logic              busy_o,
   output logic              w_ren_o,
   output logic              w_wen_o,
   output logic [WAddrW-1:0] w_addr_o,
   output logic              x_ren_o,
   output logic              x_wen_o,
   output logic              x_sel_o,
   output logic [DimW-1:0]   x_addr_o,
   output logic              acc_clr_o,
   output logic              acc_en_o
);

   localparam int LW = cnt_w(NumLayers);

   state_t            state;
   logic [LayerW-1:0] layers;
   logic              rb;
   logic              reads_done;

   logic [LW-1:0]     l;
   logic [DimW-1:0]   j;
   logic [DimW-1:0]   k;
   logic [WAddrW-1:0] n;
   logic              l_inc, j_inc, k_inc, n_inc, cnt_clr;
   logic              l_ovf, j_ovf, k_ovf, n_ovf;

   logic              init_fire, in_fire, rd_issue, beat_last, final_layer;
   logic [LayerW-1:0] clamped;
   logic [WAddrW-1:0] acc_addr;

   assign init_fire   = (state == INIT_W) && init_valid_i;
   assign in_fire     = (state == LOAD_X) && in_valid_i;
   assign rd_issue    = (state == STORE_X) && !reads_done && (!result_valid_o || result_ready_i);
   assign beat_last   = (state == STORE_X) && result_valid_o && result_ready_i && result_last_o;
   assign final_layer = l_ovf || (LayerW'(l) == layers - LayerW'(1));

   assign clamped = ((start_layers_i == '0) || (start_layers_i > LayerW'(NumLayers)))
                    ? LayerW'(NumLayers) : start_layers_i;

   // Dim is a power of two, so the l*Dim*Dim + j*Dim + k mapping is a field concatenation.
   assign acc_addr = (WAddrW'(l) << (2 * DimW)) | (WAddrW'(j) << DimW) | WAddrW'(k);

   assign cnt_clr = abort_i || beat_last;
   assign n_inc   = init_fire;
   assign k_inc   = in_fire || (state == ACC) || rd_issue;
   assign j_inc   = (state == WB);
   assign l_inc   = (state == WB) && j_ovf;

   counter #(.Limit(NumLayers), .Width(LW)) u_l (
      .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(l_inc), .clr_i(cnt_clr),
      .value_o(l), .will_overflow_o(l_ovf)
   );

   counter #(.Limit(Dim), .Width(DimW)) u_j (
      .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(j_inc), .clr_i(cnt_clr),
      .value_o(j), .will_overflow_o(j_ovf)
   );

   counter #(.Limit(Dim), .Width(DimW)) u_k (
      .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(k_inc), .clr_i(cnt_clr),
      .value_o(k), .will_overflow_o(k_ovf)
   );

   counter #(.Limit(NumLayers * Dim * Dim), .Width(WAddrW)) u_n (
      .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(n_inc), .clr_i(cnt_clr),
      .value_o(n), .will_overflow_o(n_ovf)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= IDLE;
         layers         <= '0;
         rb             <= 1'b0;
         reads_done     <= 1'b0;
         result_valid_o <= 1'b0;
         result_last_o  <= 1'b0;
         acc_en_o       <= 1'b0;
         acc_clr_o      <= 1'b0;
      end else begin
         acc_en_o  <= (state == ACC) && !abort_i;
         acc_clr_o <= (state == ACC) && (k == '0) && !abort_i;
         if (abort_i) begin
            state          <= IDLE;
            rb             <= 1'b0;
            reads_done     <= 1'b0;
            result_valid_o <= 1'b0;
            result_last_o  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (init_valid_i) begin
                     state <= INIT_W;
                  end else if (start_valid_i) begin
                     layers <= clamped;
                     state  <= LOAD_X;
                  end
               end
               INIT_W: if (n_ovf) state <= IDLE;
               LOAD_X: begin
                  if (k_ovf) begin
                     rb    <= 1'b0;
                     state <= ACC;
                  end
               end
               ACC:   if (k_ovf) state <= DRAIN;
               DRAIN: state <= WB;
               WB: begin
                  if (!j_ovf) begin
                     state <= ACC;
                  end else begin
                     rb    <= ~rb;
                     state <= final_layer ? STORE_X : ACC;
                  end
               end
               STORE_X: begin
                  // Read data holds until the next read, so a stalled beat stays put.
                  if (rd_issue) begin
                     result_valid_o <= 1'b1;
                     result_last_o  <= k_ovf;
                     if (k_ovf) reads_done <= 1'b1;
                  end else if (result_ready_i) begin
                     result_valid_o <= 1'b0;
                     result_last_o  <= 1'b0;
                  end
                  if (beat_last) begin
                     reads_done <= 1'b0;
                     state      <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy_o        = (state != IDLE);
   assign start_ready_o = (state == IDLE) && !init_valid_i;
   assign init_ready_o  = (state == INIT_W);
   assign in_ready_o    = (state == LOAD_X);
   assign w_wen_o       = init_fire;
   assign w_ren_o       = (state == ACC);
   assign x_wen_o       = in_fire || (state == WB);
   assign x_ren_o       = (state == ACC) || rd_issue;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_addr_o = '0;
      x_addr_o = '0;
      x_sel_o  = 1'b0;
      case (state)
         INIT_W:  w_addr_o = n;
         LOAD_X:  x_addr_o = k;
         ACC: begin
            w_addr_o = acc_addr;
            x_addr_o = k;
            x_sel_o  = rb;
         end
         WB: begin
            x_addr_o = j;
            x_sel_o  = ~rb;
         end
         STORE_X: begin
            x_addr_o = k;
            x_sel_o  = rb;
         end
         default: ;
      endcase
   end

endmodule
